// File: rtl/cpu_pkg.sv
// Shared CPU control-path types: machine state and jump-select
// encodings, instruction width. Imported by the fetch front end.
package cpu_pkg;

  localparam int INSTR_W = 16;

  // Encoding is shared with the decoder: HALT (11) asserts none of
  // its fetch/exec1/exec2 strobes.
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC1 = 2'b10,
    ST_EXEC2 = 2'b01,
    ST_HALT  = 2'b11
  } state_t;

  localparam logic [1:0] JS_REG    = 2'b00;
  localparam logic [1:0] JS_DIRECT = 2'b01;
  localparam logic [1:0] JS_RET    = 2'b10;

endpackage

// File: rtl/pc_unit.sv
// Program counter: jump target mux, increment and load priority.
// Ports: clock/reset, hold (freeze), sload/cnt_en, jump_sel,
// direct field, reg_target, stack_ret_addr -> target, pc.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int DIRECT_W = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hold,
  input  logic                sload,
  input  logic                cnt_en,
  input  logic [1:0]          jump_sel,
  input  logic [DIRECT_W-1:0] direct,
  input  logic [PC_W-1:0]     reg_target,
  input  logic [PC_W-1:0]     stack_ret_addr,
  output logic [PC_W-1:0]     target,
  output logic [PC_W-1:0]     pc
);

  // 11 is unused by the decoder and aliases the direct field.
  always_comb begin
    target = PC_W'(direct);
    unique case (jump_sel)
      JS_REG:  target = reg_target;
      JS_RET:  target = stack_ret_addr;
      default: target = PC_W'(direct);
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (!hold) begin
      if (sload) begin
        pc <= target;
      end else if (cnt_en) begin
        pc <= pc + PC_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// CPU front end: state machine, instruction register, PC and
// instruction-RAM address. Ports: clock/reset, ram_instr_q, decoder
// controls (sm_extra, stop, pc_sload, pc_cnt_en, jump_sel,
// ram_instr_addr_sel), reg_target, stack_ret_addr -> state,
// instruction, pc, ram_instr_addr, halted, retired_count.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int DIRECT_W = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] ram_instr_q,
  input  logic               sm_extra,
  input  logic               stop,
  input  logic               pc_sload,
  input  logic               pc_cnt_en,
  input  logic [1:0]         jump_sel,
  input  logic               ram_instr_addr_sel,
  input  logic [PC_W-1:0]    reg_target,
  input  logic [PC_W-1:0]    stack_ret_addr,
  output logic [1:0]         state,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    ram_instr_addr,
  output logic               halted,
  output logic [15:0]        retired_count
);

  state_t state_q;
  state_t state_d;
  logic [PC_W-1:0] target;
  logic pc_hold;
  logic retire;

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: state_d = ST_EXEC1;
      ST_EXEC1: state_d = sm_extra ? ST_EXEC2 : ST_FETCH;
      ST_EXEC2: state_d = ST_FETCH;
      default:  state_d = ST_HALT;
    endcase
    if (state_q != ST_HALT && stop) begin
      state_d = ST_HALT;
    end
  end

  // EXEC1->HALT is the stp instruction completing, so it retires;
  // stops taken from FETCH or EXEC2 do not.
  assign retire =
    (state_q == ST_EXEC1 && state_d != ST_EXEC2) ||
    (state_q == ST_EXEC2 && state_d == ST_FETCH);

  assign pc_hold = (state_q == ST_HALT) || stop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      instruction   <= '0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == ST_HALT);
      if (state_q == ST_FETCH) begin
        instruction <= ram_instr_q;
      end
      if (retire && retired_count != 16'hFFFF) begin
        retired_count <= retired_count + 16'd1;
      end
    end
  end

  pc_unit #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC),
    .DIRECT_W(DIRECT_W)
  ) u_pc (
    .clock         (clock),
    .reset         (reset),
    .hold          (pc_hold),
    .sload         (pc_sload),
    .cnt_en        (pc_cnt_en),
    .jump_sel      (jump_sel),
    .direct        (instruction[DIRECT_W-1:0]),
    .reg_target    (reg_target),
    .stack_ret_addr(stack_ret_addr),
    .target        (target),
    .pc            (pc)
  );

  assign ram_instr_addr = ram_instr_addr_sel ? target : pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a reference model pushes
// expected post-edge state, which is popped after each edge.
module tb_fetch_sequencer;

  localparam logic [1:0] F  = 2'b00;
  localparam logic [1:0] E1 = 2'b10;
  localparam logic [1:0] E2 = 2'b01;
  localparam logic [1:0] H  = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ram_instr_q;
  logic        sm_extra = 0;
  logic        stop = 0;
  logic        pc_sload = 0;
  logic        pc_cnt_en = 0;
  logic [1:0]  jump_sel = 0;
  logic        ram_instr_addr_sel = 0;
  logic [15:0] reg_target = 0;
  logic [15:0] stack_ret_addr = 0;
  logic [1:0]  state;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic [15:0] ram_instr_addr;
  logic        halted;
  logic [15:0] retired_count;

  logic [15:0] mem [0:4095];
  assign ram_instr_q = mem[ram_instr_addr[11:0]];

  fetch_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .ram_instr_q       (ram_instr_q),
    .sm_extra          (sm_extra),
    .stop              (stop),
    .pc_sload          (pc_sload),
    .pc_cnt_en         (pc_cnt_en),
    .jump_sel          (jump_sel),
    .ram_instr_addr_sel(ram_instr_addr_sel),
    .reg_target        (reg_target),
    .stack_ret_addr    (stack_ret_addr),
    .state             (state),
    .instruction       (instruction),
    .pc                (pc),
    .ram_instr_addr    (ram_instr_addr),
    .halted            (halted),
    .retired_count     (retired_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] rc;
    logic        hl;
  } exp_t;

  exp_t exp_q[$];

  logic [1:0]  m_st;
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_rc;
  logic        m_hl;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Called just after a rising edge; returns just after the next.
  task automatic step(input logic ex, input logic st,
                      input logic ld, input logic ce,
                      input logic [1:0] js, input logic as,
                      input logic [15:0] rt = 16'h0,
                      input logic [15:0] ra = 16'h0);
    logic [15:0] tgt;
    logic [15:0] addr;
    exp_t n;
    exp_t e;
    sm_extra = ex;
    stop = st;
    pc_sload = ld;
    pc_cnt_en = ce;
    jump_sel = js;
    ram_instr_addr_sel = as;
    reg_target = rt;
    stack_ret_addr = ra;
    #1;
    if (js == 2'b00) tgt = rt;
    else if (js == 2'b10) tgt = ra;
    else tgt = {4'h0, m_ir[11:0]};
    addr = as ? tgt : m_pc;
    check("ram_addr", 32'(ram_instr_addr), 32'(addr));
    n.st = m_st;
    n.pc = m_pc;
    n.ir = m_ir;
    n.rc = m_rc;
    if (m_st != H) begin
      if (m_st == F) n.ir = mem[addr[11:0]];
      if (st) begin
        n.st = H;
        if (m_st == E1) n.rc = sat(m_rc);
      end else begin
        case (m_st)
          F:       n.st = E1;
          E1:      n.st = ex ? E2 : F;
          default: n.st = F;
        endcase
        if ((m_st == E1 && !ex) || m_st == E2)
          n.rc = sat(m_rc);
        if (ld) n.pc = tgt;
        else if (ce) n.pc = m_pc + 16'd1;
      end
    end
    n.hl = (n.st == H);
    exp_q.push_back(n);
    m_st = n.st;
    m_pc = n.pc;
    m_ir = n.ir;
    m_rc = n.rc;
    m_hl = n.hl;
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("state", 32'(state), 32'(e.st));
    check("pc", 32'(pc), 32'(e.pc));
    check("instr", 32'(instruction), 32'(e.ir));
    check("retired", 32'(retired_count), 32'(e.rc));
    check("halted", 32'(halted), 32'(e.hl));
  endtask

  // Asserts reset between edges and checks it acts immediately.
  task automatic do_reset;
    #1 reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'(F));
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_retired", 32'(retired_count), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    m_st = F;
    m_pc = 16'h0;
    m_ir = 16'h0;
    m_rc = 16'h0;
    m_hl = 1'b0;
    exp_q.delete();
    #1 reset = 1'b0;
  endtask

  logic [15:0] rc_b;
  logic [15:0] pc_b;
  logic [15:0] ir_b;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h4000;
    mem[7]     = 16'hC123;
    mem[12'h456] = 16'hC0AB;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // sequential fetch
    repeat (4) step(0, 0, 0, 1, 2'b00, 0);
    check("seq_pc", 32'(pc), 32'h4);
    check("seq_retired", 32'(retired_count), 32'h2);

    // two-word instruction
    step(0, 0, 0, 1, 2'b00, 0);
    step(1, 0, 0, 1, 2'b00, 0);
    check("ex2_state", 32'(state), 32'(E2));
    check("ex2_retired", 32'(retired_count), 32'h2);
    step(0, 0, 0, 1, 2'b00, 0);
    check("ex2_done", 32'(retired_count), 32'h3);

    // direct jump with RAM address redirected the same cycle
    step(0, 0, 0, 1, 2'b00, 0);
    check("dj_instr", 32'(instruction), 32'hC123);
    step(0, 0, 1, 0, 2'b01, 1);
    check("dj_pc", 32'(pc), 32'h0123);

    // return: load beats count
    step(0, 0, 0, 1, 2'b00, 0);
    step(0, 0, 1, 1, 2'b10, 0, 16'h0, 16'h0456);
    check("ret_pc", 32'(pc), 32'h0456);

    // jump_sel 11 aliases direct
    step(0, 0, 0, 1, 2'b00, 0);
    step(0, 0, 1, 0, 2'b11, 0, 16'h1111, 16'h2222);
    check("js11_pc", 32'(pc), 32'h00AB);

    // register target to FFFF, then wrap
    step(0, 0, 0, 1, 2'b00, 0);
    step(0, 0, 1, 0, 2'b00, 0, 16'hFFFF);
    check("reg_pc", 32'(pc), 32'hFFFF);
    step(0, 0, 0, 1, 2'b00, 0);
    check("wrap_pc", 32'(pc), 32'h0000);
    step(0, 0, 0, 0, 2'b00, 0);

    // halt from EXEC1, then frozen for 20 cycles
    step(0, 0, 0, 1, 2'b00, 0);
    rc_b = retired_count;
    step(0, 1, 0, 1, 2'b00, 0);
    check("halt_state", 32'(state), 32'(H));
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_rc", 32'(retired_count), 32'(rc_b + 16'd1));
    pc_b = pc;
    ir_b = instruction;
    repeat (20)
      step(1'($urandom), 1'($urandom), 1, 1,
           2'($urandom), 0, 16'($urandom), 16'($urandom));
    check("frz_pc", 32'(pc), 32'(pc_b));
    check("frz_instr", 32'(instruction), 32'(ir_b));
    check("frz_rc", 32'(retired_count), 32'(rc_b + 16'd1));

    // async reset mid-EXEC2 with pc at FFFF
    do_reset();
    step(0, 0, 0, 0, 2'b00, 0);
    step(1, 0, 1, 0, 2'b00, 0, 16'hFFFF);
    check("e2_pc", 32'(pc), 32'hFFFF);
    do_reset();

    // stop in FETCH: no retire
    step(0, 1, 0, 1, 2'b00, 0);
    check("fstop_rc", 32'(retired_count), 32'h0);
    check("fstop_state", 32'(state), 32'(H));
    do_reset();

    // stop in EXEC2: no retire
    step(0, 0, 0, 1, 2'b00, 0);
    step(1, 0, 0, 1, 2'b00, 0);
    step(0, 1, 0, 1, 2'b00, 0);
    check("e2stop_rc", 32'(retired_count), 32'h0);
    check("e2stop_pc", 32'(pc), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
